// File: rtl/ps2_keyboard_pkg.sv
// ps2_keyboard_pkg -- shared constants, receiver state encoding and parity helper
// Revision 1.0
`default_nettype none

package ps2_keyboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int         PS2_FILTER_LEN      = 4;
  localparam int         PS2_TIMEOUT_DEFAULT = 12500;
  localparam logic [7:0] PS2_BREAK_CODE      = 8'hF0;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_keyboard_if.sv
// ps2_keyboard_if -- host-side read port of the PS/2 keyboard receiver
// Revision 1.0
`default_nettype none

interface ps2_keyboard_if;
  logic       ps2i_rdn;
  logic [7:0] ps2o_scan_code;
  logic       ps2o_data_ready;
  logic       ps2o_frame_err;
  logic       ps2o_overflow;

  modport master (
    output ps2i_rdn,
    input  ps2o_scan_code,
    input  ps2o_data_ready,
    input  ps2o_frame_err,
    input  ps2o_overflow
  );

  modport slave (
    input  ps2i_rdn,
    output ps2o_scan_code,
    output ps2o_data_ready,
    output ps2o_frame_err,
    output ps2o_overflow
  );
endinterface

`default_nettype wire

// File: rtl/ps2_keyboard_fifo.sv
// ps2_fifo -- power-of-two scan-code buffer with a registered head byte (0 when empty)
// Revision 1.0
`default_nettype none

module ps2_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  wire logic             clk_i,
  input  wire logic             rst_ni,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] data_i,
  input  wire logic             pop_i,
  output logic      [WIDTH-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic      [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    rd_ptr_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = head_q;

  // Head is precomputed so the visible byte is a plain register; a push into
  // the slot that becomes the head must bypass the not-yet-written memory.
  always_comb begin
    w_do_pop  = pop_i && (count_q != '0);
    w_do_push = push_i && (!full_o || w_do_pop);
    rd_ptr_d  = rd_ptr_q + PW'(w_do_pop);
    count_d   = count_q + CW'(w_do_push) - CW'(w_do_pop);
    if (count_d == '0) begin
      head_d = '0;
    end else if (w_do_push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(w_do_push);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_keyboard.sv
// ps2_keyboard -- PS/2 keyboard receiver with glitch filter, timeout and scan-code FIFO.
// Optional macro PS2_BREAK_FILTER_EN drops 8'hF0 and the byte after it. Revision 1.0
`default_nettype none

module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
  input  wire logic      ps2i_clk,
  input  wire logic      ps2i_rst,
  input  wire logic      ps2i_kbd_clk,
  input  wire logic      ps2i_kbd_data,
  ps2_keyboard_if.slave  bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]                kclk_sync_q;
  logic [1:0]                kdat_sync_q;
  logic [PS2_FILTER_LEN-1:0] kclk_hist_q;
  logic                      kclk_filt_q;
  logic                      sample_q;

  ps2_state_e                state_q;
  logic [2:0]                bitcnt_q;
  logic [7:0]                shift_q;
  logic                      par_ok_q;
  logic [TW-1:0]             tmo_q;
  logic                      push_q;
  logic                      frame_err_q;
  logic                      rdn_q;
  logic                      overflow_q;

  logic                      w_kdat;
  logic                      w_timeout;
  logic                      w_stop_evt;
  logic                      w_byte_ok;
  logic                      w_frame_bad;
  logic                      w_deliver;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic [CW-1:0]             w_count;
  logic [7:0]                w_head;

  always_ff @(posedge ps2i_clk or negedge ps2i_rst) begin
    if (!ps2i_rst) begin
      kclk_sync_q <= 2'b11;
      kdat_sync_q <= 2'b11;
      kclk_hist_q <= '1;
      kclk_filt_q <= 1'b1;
      sample_q    <= 1'b0;
    end else begin
      kclk_sync_q <= {kclk_sync_q[0], ps2i_kbd_clk};
      kdat_sync_q <= {kdat_sync_q[0], ps2i_kbd_data};
      kclk_hist_q <= {kclk_hist_q[PS2_FILTER_LEN-2:0], kclk_sync_q[1]};
      if (&kclk_hist_q) begin
        kclk_filt_q <= 1'b1;
      end else if (~|kclk_hist_q) begin
        kclk_filt_q <= 1'b0;
      end
      sample_q <= kclk_filt_q && (~|kclk_hist_q);
    end
  end

  assign w_kdat      = kdat_sync_q[1];
  assign w_timeout   = (state_q != ST_IDLE) && !sample_q && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign w_stop_evt  = sample_q && (state_q == ST_STOP);
  assign w_byte_ok   = w_stop_evt && w_kdat && par_ok_q;
  assign w_frame_bad = w_timeout || (w_stop_evt && !(w_kdat && par_ok_q));

`ifdef PS2_BREAK_FILTER_EN
  logic skip_q;

  // A break prefix suppresses itself and the key code that follows it.
  always_ff @(posedge ps2i_clk or negedge ps2i_rst) begin
    if (!ps2i_rst) begin
      skip_q <= 1'b0;
    end else if (w_frame_bad) begin
      skip_q <= 1'b0;
    end else if (w_byte_ok) begin
      skip_q <= !skip_q && (shift_q == PS2_BREAK_CODE);
    end
  end

  assign w_deliver = w_byte_ok && !skip_q && (shift_q != PS2_BREAK_CODE);
`else
  assign w_deliver = w_byte_ok;
`endif

  always_ff @(posedge ps2i_clk or negedge ps2i_rst) begin
    if (!ps2i_rst) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      par_ok_q    <= 1'b0;
      tmo_q       <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_q      <= w_deliver;
      frame_err_q <= w_frame_bad;
      if ((state_q == ST_IDLE) || sample_q) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
      if (w_timeout) begin
        state_q <= ST_IDLE;
      end else if (sample_q) begin
        case (state_q)
          ST_IDLE: begin
            if (!w_kdat) begin
              state_q  <= ST_DATA;
              bitcnt_q <= 3'd0;
            end
          end
          ST_DATA: begin
            shift_q  <= {w_kdat, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_q <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_ok_q <= odd_parity_ok(shift_q, w_kdat);
            state_q  <= ST_STOP;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // One pop per read: on the rising edge of the active-low strobe.
  always_ff @(posedge ps2i_clk or negedge ps2i_rst) begin
    if (!ps2i_rst) begin
      rdn_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      rdn_q <= bus.ps2i_rdn;
      if (push_q && w_full && !w_pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign w_pop = bus.ps2i_rdn && !rdn_q && (w_count != '0);

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (ps2i_clk),
    .rst_ni  (ps2i_rst),
    .push_i  (push_q),
    .data_i  (shift_q),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign bus.ps2o_scan_code  = w_head;
  assign bus.ps2o_data_ready = !w_empty;
  assign bus.ps2o_frame_err  = frame_err_q;
  assign bus.ps2o_overflow   = overflow_q;

endmodule

`default_nettype wire

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, scan-code buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 12500, system clocks without a PS/2 falling edge before an in-progress frame is abandoned (250 us at 50 MHz).
REQ-003 SHALL have port ps2i_clk  in  1  system clock, 50 MHz, all state on rising edge.
REQ-004 SHALL have port ps2i_rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ps2i_kbd_clk  in  1  raw PS/2 device clock, asynchronous.
REQ-006 SHALL have port ps2i_kbd_data  in  1  raw PS/2 device data, asynchronous.
REQ-007 SHALL have port ps2i_rdn  in  1  read strobe from MEM stage, active-low, same clock domain, may stay low several cycles.
REQ-008 SHALL have port ps2o_scan_code  out  8  FIFO head byte; 8'h00 when empty.
REQ-009 SHALL have port ps2o_data_ready  out  1  high while FIFO non-empty.
REQ-010 SHALL have port ps2o_frame_err  out  1  one-cycle pulse per discarded frame.
REQ-011 SHALL have port ps2o_overflow  out  1  sticky; set when a valid byte is dropped because FIFO full.

Function
REQ-012 SHALL pass ps2i_kbd_clk and ps2i_kbd_data each through a 2-flop synchronizer.
REQ-013 SHALL filter the synchronized PS/2 clock: level accepted only after 4 consecutive equal samples; a falling edge of the filtered clock is the sample event.
REQ-014 SHALL receive frames via FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on sample events.
REQ-015 IDLE: sample event with data 0 -> DATA, bit counter 0; data 1 -> stay IDLE, no error.
REQ-016 DATA: shift data in LSB first; after 8th bit -> PARITY.
REQ-017 PARITY: sampled bit SHALL make the 9 bits odd parity, else frame error; -> STOP either way.
REQ-018 STOP: data 1 and parity good -> byte valid; otherwise frame error; -> IDLE.
REQ-019 Valid byte SHALL be pushed into FIFO the cycle after the stop sample event.
REQ-020 In DATA/PARITY/STOP, TIMEOUT_CYCLES clocks without sample event SHALL return FSM to IDLE, pulse ps2o_frame_err, discard partial byte.
REQ-021 Pop SHALL occur once per read: on the cycle ps2i_rdn is seen high after having been low the previous cycle (rising edge), only if non-empty; pop on empty ignored.
REQ-022 ps2o_scan_code and ps2o_data_ready SHALL be registered FIFO state, stable while ps2i_rdn low.
REQ-023 Push when full and no pop in same cycle: byte dropped, ps2o_overflow set, FIFO unchanged.
REQ-024 Simultaneous push and pop: both SHALL occur, including when full; count unchanged.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty via count of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-026 ps2i_rst low SHALL asynchronously force FSM IDLE, FIFO empty, pointers 0, ps2o_scan_code 8'h00, ps2o_data_ready 0, ps2o_frame_err 0, ps2o_overflow 0, synchronizers and filter to 1, rdn edge register 1, timeout counter 0, filter state cleared.
REQ-027 Reset mid-frame SHALL discard the partial byte; reception resumes at next start bit after release.

Configuration
REQ-028 Macro PS2_BREAK_FILTER_EN defined: byte 8'hF0 and the byte following it SHALL NOT enter FIFO (only make codes delivered; 8'hE0 prefixes pass); a frame error clears the pending-skip flag.
REQ-029 PS2_BREAK_FILTER_EN undefined: every valid byte SHALL enter FIFO; no skip flag logic present.

Structure
REQ-030 PS/2 FSM state encodings, filter length 4 and default timeout SHALL be constants in shared defines.v, beside ADDR_KEYBOARD/ADDR_KEYBOARD_STATE.
REQ-031 Buffer SHALL be sub-module ps2_fifo (parameterised depth, 8-bit, push/pop/full/empty/count); receiver FSM stays in ps2_keyboard.

Verification
REQ-032 Frame 8'h1C (A make), correct parity, 12.5 kHz PS/2 clock -> data_ready 1, scan_code 8'h1C; rdn low 3 cycles then high -> data_ready 0, scan_code 8'h00, exactly one pop.
REQ-033 Frame 8'h1C with wrong parity -> one frame_err pulse, data_ready stays 0.
REQ-034 Six valid bytes 8'h01..8'h06, no reads, depth 4 -> overflow 1; reads return 8'h01..8'h04 then empty.
REQ-035 Start bit plus 3 data bits then clock stops 300 us -> frame_err pulse, FSM IDLE; next full frame 8'h29 received correctly.
REQ-036 With PS2_BREAK_FILTER_EN: sequence 8'h1C, 8'hF0, 8'h1C -> FIFO holds only one 8'h1C; without macro -> three entries.
REQ-037 Reset asserted after 5 data bits, released, then frame 8'h5A -> only 8'h5A in FIFO, no frame_err.
